fifo_frame_reader: RTL and testbench

Drain-side companion to `sync_fifo_core` (FWFT mode) on the switch egress path. It pops length-prefixed frames from the FIFO and emits them as a valid/ready word stream with an end-of-frame marker. A two-word big-endian length header precedes each frame's payload in the FIFO. The block counts forwarded and zero-length frames for status registers.

---
 rtl/fifo_frame_reader_pkg.sv | 13 +
 rtl/fifo_frame_reader_stream_out_reg.sv | 40 ++++
 rtl/fifo_frame_reader.sv | 134 +++++++++++++
 tb/tb_fifo_frame_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_reader_pkg.sv
// Shared types and constants for the length-prefixed frame reader.
`timescale 1ns/1ps
package fifo_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_HDR_HI  = 2'd0,
    ST_HDR_LO  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  localparam int HDR_WORDS = 2;

endpackage

// File: rtl/fifo_frame_reader_stream_out_reg.sv
// One-entry valid/ready output register carrying a data word and its last flag.
`timescale 1ns/1ps
module stream_out_reg #(
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [P_DATA_WIDTH-1:0] load_data,
  input  logic                    load_last,
  input  logic                    ready,
  output logic                    valid,
  output logic [P_DATA_WIDTH-1:0] data,
  output logic                    last
);

  logic                    valid_reg;
  logic [P_DATA_WIDTH-1:0] data_reg;
  logic                    last_reg;

  // A load wins over a drain, so transfer+load keeps valid high with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      last_reg  <= load_last;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign last  = last_reg;

endmodule

// File: rtl/fifo_frame_reader.sv
// Pops length-prefixed frames from an FWFT FIFO and emits them as a valid/ready
// word stream with an end-of-frame marker, counting forwarded and empty frames.
`timescale 1ns/1ps
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    fifo_empty_i,
  input  logic [P_DATA_WIDTH-1:0] fifo_data_i,
  output logic                    fifo_rd_o,
  output logic                    m_valid_o,
  output logic [P_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  input  logic                    m_ready_i,
  output logic                    busy_o,
  output logic [P_CNT_WIDTH-1:0]  frame_cnt_o,
  output logic [P_CNT_WIDTH-1:0]  zero_cnt_o
);

  localparam int LEN_WIDTH = HDR_WORDS * P_DATA_WIDTH;

  state_t                  state_reg, state_next;
  logic [P_DATA_WIDTH-1:0] len_hi_reg, len_hi_next;
  logic [LEN_WIDTH-1:0]    rem_reg, rem_next;
  logic [P_CNT_WIDTH-1:0]  frame_cnt_reg, zero_cnt_reg;

  logic [LEN_WIDTH-1:0]    len;
  logic                    pop_ok;
  logic                    xfer;
  logic                    load;
  logic                    load_last;
  logic                    zero_hit;

  assign len       = {len_hi_reg, fifo_data_i};
  assign pop_ok    = !fifo_empty_i && (!m_valid_o || m_ready_i);
  assign xfer      = m_valid_o && m_ready_i;
  assign load_last = (rem_reg == LEN_WIDTH'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_HDR_HI;
      len_hi_reg <= '0;
      rem_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      len_hi_reg <= len_hi_next;
      rem_reg    <= rem_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    len_hi_next = len_hi_reg;
    rem_next    = rem_reg;
    fifo_rd_o   = 1'b0;
    load        = 1'b0;
    zero_hit    = 1'b0;
    case (state_reg)
      ST_HDR_HI: begin
        if (en_i && !fifo_empty_i) begin
          fifo_rd_o   = 1'b1;
          len_hi_next = fifo_data_i;
          state_next  = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (!fifo_empty_i) begin
          fifo_rd_o = 1'b1;
          if (len == '0) begin
            zero_hit   = 1'b1;
            state_next = ST_HDR_HI;
          end else begin
            rem_next   = len;
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pop_ok) begin
          fifo_rd_o = 1'b1;
          load      = 1'b1;
          rem_next  = rem_reg - LEN_WIDTH'(1);
          if (load_last) begin
            state_next = ST_HDR_HI;
          end
        end
      end
      default: state_next = ST_HDR_HI;
    endcase
    // The pop strobe must stay low while reset holds the FSM, whatever the FIFO shows.
    if (rst_i) begin
      fifo_rd_o = 1'b0;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_reg <= '0;
      zero_cnt_reg  <= '0;
    end else begin
      if (xfer && m_last_o) begin
        frame_cnt_reg <= frame_cnt_reg + P_CNT_WIDTH'(1);
      end
      if (zero_hit) begin
        zero_cnt_reg <= zero_cnt_reg + P_CNT_WIDTH'(1);
      end
    end
  end

  stream_out_reg #(
    .P_DATA_WIDTH(P_DATA_WIDTH)
  ) u_out (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (load),
    .load_data (fifo_data_i),
    .load_last (load_last),
    .ready     (m_ready_i),
    .valid     (m_valid_o),
    .data      (m_data_o),
    .last      (m_last_o)
  );

  assign busy_o      = (state_reg != ST_HDR_HI) || m_valid_o;
  assign frame_cnt_o = frame_cnt_reg;
  assign zero_cnt_o  = zero_cnt_reg;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader: FIFO model, output scoreboard,
// a cycle table for the first frame and directed multi-cycle corner cases.
`timescale 1ns/1ps
module tb_fifo_frame_reader;

  localparam int W  = 8;
  localparam int CW = 16;
  localparam int LW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data = '0;
  logic          fifo_rd;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] zero_cnt;

  always #5 clk = ~clk;

  fifo_frame_reader #(
    .P_DATA_WIDTH(W),
    .P_CNT_WIDTH (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_o    (fifo_rd),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_last_o     (m_last),
    .m_ready_i    (m_ready),
    .busy_o       (busy),
    .frame_cnt_o  (frame_cnt),
    .zero_cnt_o   (zero_cnt)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    logic          ready;
    logic          valid;
    logic [W-1:0]  data;
    logic          last;
    logic          rd;
    logic          busy;
    logic [CW-1:0] frames;
  } vec_t;

  logic [W-1:0] fifo_q[$];
  exp_t         exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           exp_frames = 0;
  int           exp_zero = 0;
  bit           rand_ready = 1'b0;
  bit           chk_nopop = 1'b0;
  logic         rd_s = 1'b0;
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic         prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  // stride 0 selects random payload bytes
  task automatic push_frame(input int len, input logic [W-1:0] base, input int stride);
    logic [LW-1:0] l;
    logic [W-1:0]  d;
    l = LW'(len);
    fifo_q.push_back(l[LW-1:W]);
    fifo_q.push_back(l[W-1:0]);
    for (int i = 0; i < len; i++) begin
      d = (stride == 0) ? W'($urandom) : W'(32'(base) + 32'(i * stride));
      fifo_q.push_back(d);
      exp_q.push_back('{data: d, last: (i == len - 1)});
    end
    if (len == 0) exp_zero++;
    else exp_frames++;
    refresh();
  endtask

  task automatic check_outputs();
    exp_t e;
    if (fifo_empty) check("rd_while_empty", 32'(fifo_rd), 32'd0);
    if (prev_valid && !prev_ready) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(prev_data));
      check("hold_last", 32'(m_last), 32'(prev_last));
    end
    if (chk_nopop && m_valid && !m_ready) check("pop_while_stalled", 32'(fifo_rd), 32'd0);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %0h, required no transfer", m_data);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", 32'(m_data), 32'(e.data));
        check("xfer_last", 32'(m_last), 32'(e.last));
        $display("xfer data=%02h last=%0b", m_data, m_last);
      end
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic to_negedge();
    @(negedge clk);
    check_outputs();
    rd_s = fifo_rd;
  endtask

  task automatic to_edge();
    logic [W-1:0] junk;
    @(posedge clk);
    #1;
    if (rd_s && fifo_q.size() > 0) junk = fifo_q.pop_front();
    refresh();
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    to_negedge();
    to_edge();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(fifo_empty && !busy) && n < budget);
    check({name, "_drained"}, 32'(n < budget), 32'd1);
    check({name, "_scoreboard_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({name, "_zero_cnt"}, 32'(zero_cnt), 32'(exp_zero));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   start_frames;

    // Frame 00 03 A1 A2 A3, one row per cycle after reset release.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[4] = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 16'd0};
    vecs[5] = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};

    rst = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    push_frame(3, 8'hA1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", 32'(fifo_rd), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_zero_cnt", 32'(zero_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      m_ready = vecs[i].ready;
      to_negedge();
      check($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("tbl%0d_data", i), 32'(m_data), 32'(vecs[i].data));
        check($sformatf("tbl%0d_last", i), 32'(m_last), 32'(vecs[i].last));
      end
      check($sformatf("tbl%0d_rd", i), 32'(fifo_rd), 32'(vecs[i].rd));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("tbl%0d_frames", i), 32'(frame_cnt), 32'(vecs[i].frames));
      to_edge();
    end
    wait_idle("basic", 50);

    // Zero-length header, then a one-word frame.
    push_frame(0, 8'h00, 1);
    push_frame(1, 8'h5C, 1);
    wait_idle("zero_len", 50);

    // Backpressure pattern 1,0,0,1 with stability and no-pop checks.
    chk_nopop = 1'b1;
    push_frame(4, 8'h11, 17);
    for (int i = 0; i < 20; i++) begin
      m_ready = ((i % 4) == 0) || ((i % 4) == 3);
      step();
    end
    chk_nopop = 1'b0;
    m_ready = 1'b1;
    wait_idle("backpressure", 50);

    // en dropped mid-frame: frame finishes, next header stays in the FIFO.
    push_frame(2, 8'hAA, 17);
    push_frame(1, 8'hCC, 1);
    repeat (3) step();
    en = 1'b0;
    repeat (10) step();
    check("en_hold_fifo_words", 32'(fifo_q.size()), 32'd3);
    check("en_hold_busy", 32'(busy), 32'd0);
    check("en_hold_frame_cnt", 32'(frame_cnt), 32'(exp_frames - 1));
    en = 1'b1;
    wait_idle("en_resume", 50);

    // Reset after two of five payload words; leftover bytes form a 1-word frame.
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h05);
    fifo_q.push_back(8'h31);
    fifo_q.push_back(8'h32);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'hE5);
    refresh();
    exp_q.push_back('{data: 8'h31, last: 1'b0});
    repeat (4) step();
    rst = 1'b1;
    #2;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_data", 32'(m_data), 32'd0);
    check("midrst_last", 32'(m_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd", 32'(fifo_rd), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_zero_cnt", 32'(zero_cnt), 32'd0);
    check("midrst_sent_words", 32'(exp_q.size()), 32'd0);
    exp_frames = 0;
    exp_zero = 0;
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back('{data: 8'hE5, last: 1'b1});
    exp_frames = 1;
    wait_idle("after_reset", 50);

    // Length with a nonzero high byte.
    push_frame(257, 8'h00, 1);
    wait_idle("long_frame", 400);

    // Random bursts with random ready.
    start_frames = exp_frames;
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      push_frame(int'($urandom_range(1, 20)), 8'h00, 0);
      repeat ($urandom_range(0, 15)) step();
    end
    wait_idle("random", 6000);
    rand_ready = 1'b0;
    check("random_frames", 32'(frame_cnt) - 32'(start_frames), 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
